// File: rtl/bit_serial_alu_pkg.sv
// Shared types for the bit-serial ALU: operation modes and controller states.
package bit_serial_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_CMP  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bit_serial_alu_slice.sv
// One-bit cascade cell: full-adder sum/carry, transparent for the cascade when disabled.
module bsa_slice (
    input  logic en,
    input  logic x,
    input  logic y,
    input  logic k_in,
    output logic u,
    output logic k_out
);

    assign u     = en ? (x ^ y ^ k_in) : 1'b0;
    assign k_out = en ? ((x & y) | (x & k_in) | (y & k_in)) : k_in;

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial add/sub/compare engine: one operand bit per clock, LSB first,
// cascade bit carried in r_k between cycles.
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_RUN  | one bit per enabled cycle, WIDTH bits total
// S_DONE | one-cycle done pulse, flags valid
module bit_serial_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             k_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] u,
    output logic             k_out,
    output logic             eq,
    output logic             gt
);
    import bit_serial_alu_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_u;
    logic [CNT_W-1:0] r_cnt;
    logic             r_k;
    logic             r_busy;
    logic             r_done;
    logic             r_k_out;
    logic             r_eq;
    logic             r_gt;

    logic             w_slice_en;
    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_u_next;
    logic             w_inv_y;

    assign w_slice_en = (r_state == S_RUN) && en;
    assign w_u_next   = {w_sum, r_u[WIDTH-1:1]};
    assign w_inv_y    = (mode == MODE_SUB) || (mode == MODE_CMP);

    bsa_slice u_slice (
        .en    (w_slice_en),
        .x     (r_x[0]),
        .y     (r_y[0]),
        .k_in  (r_k),
        .u     (w_sum),
        .k_out (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_ADD;
            r_x     <= '0;
            r_y     <= '0;
            r_u     <= '0;
            r_cnt   <= '0;
            r_k     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_k_out <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= w_inv_y ? ~y : y;
                        r_mode  <= mode_t'(mode);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                        // Subtraction runs as x + ~y + carry, so borrow-in enters inverted.
                        case (mode_t'(mode))
                            MODE_SUB: r_k <= ~k_in;
                            MODE_CMP: r_k <= 1'b1;
                            default:  r_k <= k_in;
                        endcase
                    end
                end
                S_RUN: begin
                    if (en) begin
                        r_x   <= r_x >> 1;
                        r_y   <= r_y >> 1;
                        r_u   <= w_u_next;
                        r_k   <= w_carry;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            case (r_mode)
                                MODE_SUB: begin
                                    r_k_out <= ~w_carry;
                                    r_eq    <= 1'b0;
                                    r_gt    <= 1'b0;
                                end
                                MODE_CMP: begin
                                    r_k_out <= ~w_carry;
                                    r_eq    <= (w_u_next == '0);
                                    r_gt    <= w_carry && (w_u_next != '0);
                                end
                                default: begin
                                    r_k_out <= w_carry;
                                    r_eq    <= 1'b0;
                                    r_gt    <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign u     = r_u;
    assign k_out = r_k_out;
    assign eq    = r_eq;
    assign gt    = r_gt;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu: directed cases plus randomized ops vs. an arithmetic model.
module tb_bit_serial_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         k_in;
    logic         busy;
    logic         done;
    logic [W-1:0] u;
    logic         k_out;
    logic         eq;
    logic         gt;

    int n_tests = 0;
    int n_fail  = 0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .mode  (mode),
        .x     (x),
        .y     (y),
        .k_in  (k_in),
        .busy  (busy),
        .done  (done),
        .u     (u),
        .k_out (k_out),
        .eq    (eq),
        .gt    (gt)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ki, output logic [W-1:0] eu, output logic ek,
                                  output logic eeq, output logic egt);
        longint r;
        eeq = 1'b0;
        egt = 1'b0;
        case (m)
            2'd1: begin
                r  = longint'(a) - longint'(b) - longint'(ki);
                ek = (r < 0);
            end
            2'd2: begin
                r   = longint'(a) - longint'(b);
                ek  = (a < b);
                eeq = (a == b);
                egt = (a > b);
            end
            default: begin
                r  = longint'(a) + longint'(b) + longint'(ki);
                ek = (r >= (longint'(1) << W));
            end
        endcase
        eu = W'(r & ((longint'(1) << W) - 1));
    endfunction

    // Drives one operation from a negedge in IDLE and observes it until three cycles past done.
    // lat is the cycle number in which done is first seen (start edge = edge 0), -1 on timeout.
    task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ki, input int sf, input int sl, input int ra,
                         input logic [1:0] rm, input logic [W-1:0] rx, input logic [W-1:0] ry,
                         output int lat, output int n_done, output bit busy_bad,
                         output bit u_moved, output bit busy_tail);
        int e;
        int e_done;
        bit stall;
        logic [W-1:0] prev_u;
        mode = m; x = a; y = b; k_in = ki; en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0; e_done = -1; n_done = 0; busy_bad = 0; u_moved = 0; busy_tail = 0;
        for (int it = 0; it < 300; it++) begin
            stall = (e >= sf) && (e < sf + sl);
            en = !stall;
            if (e == ra) begin
                start = 1'b1; mode = rm; x = rx; y = ry;
            end else begin
                start = 1'b0;
            end
            prev_u = u;
            @(negedge clk);
            e++;
            if (e_done < 0) begin
                if (stall && u !== prev_u) u_moved = 1;
                if (busy !== 1'b1) busy_bad = 1;
            end
            if (done === 1'b1) begin
                n_done++;
                if (e_done < 0) e_done = e;
            end
            if (e_done >= 0 && e > e_done && busy !== 1'b0) busy_tail = 1;
            if (e_done >= 0 && e == e_done + 3) break;
        end
        start = 1'b0;
        en = 1'b1;
        lat = (e_done >= 0) ? e_done + 1 : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; en = 1'b1; mode = 2'd0; x = '0; y = '0; k_in = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, u, k_out, eq, gt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b u=%0d k=%b eq=%b gt=%b, expected all 0",
                     busy, done, u, k_out, eq, gt);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, u} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b u=%0d, expected 0 0 0", busy, done, u);
        end
    endtask

    task automatic test_add();
        int lat, nd; bit bb, um, bt;
        do_op(2'd0, 8'd200, 8'd100, 1'b1, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (lat !== W + 1) begin n_fail++; $display("FAIL add_latency: got cycle %0d, expected %0d", lat, W + 1); end
        n_tests++;
        if (u !== 8'd45 || k_out !== 1'b1 || eq !== 1'b0 || gt !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: got u=%0d k=%b eq=%b gt=%b, expected u=45 k=1 eq=0 gt=0", u, k_out, eq, gt);
        end
        n_tests++;
        if (nd !== 1 || bb || bt) begin
            n_fail++;
            $display("FAIL add_handshake: got done_pulses=%0d busy_gap=%b busy_late=%b, expected 1 0 0", nd, bb, bt);
        end
    endtask

    task automatic test_sub();
        int lat, nd; bit bb, um, bt;
        do_op(2'd1, 8'd5, 8'd7, 1'b0, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (u !== 8'd254 || k_out !== 1'b1 || eq !== 1'b0 || gt !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_5_7: got u=%0d k=%b eq=%b gt=%b, expected u=254 k=1 eq=0 gt=0", u, k_out, eq, gt);
        end
        do_op(2'd1, 8'd7, 8'd5, 1'b1, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (u !== 8'd1 || k_out !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_7_5_b1: got u=%0d k=%b, expected u=1 k=0", u, k_out);
        end
    endtask

    task automatic test_compare();
        int lat, nd; bit bb, um, bt;
        do_op(2'd2, 8'd9, 8'd9, 1'b1, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (eq !== 1'b1 || gt !== 1'b0 || k_out !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_9_9: got eq=%b gt=%b k=%b, expected 1 0 0", eq, gt, k_out);
        end
        do_op(2'd2, 8'd10, 8'd3, 1'b0, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (eq !== 1'b0 || gt !== 1'b1 || k_out !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_10_3: got eq=%b gt=%b k=%b, expected 0 1 0", eq, gt, k_out);
        end
        do_op(2'd2, 8'd3, 8'd10, 1'b0, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (eq !== 1'b0 || gt !== 1'b0 || k_out !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_3_10: got eq=%b gt=%b k=%b, expected 0 0 1", eq, gt, k_out);
        end
    endtask

    task automatic test_stall();
        int lat, nd; bit bb, um, bt;
        do_op(2'd0, 8'd1, 8'd1, 1'b0, 3, 3, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (lat !== W + 4) begin n_fail++; $display("FAIL stall_latency: got cycle %0d, expected %0d", lat, W + 4); end
        n_tests++;
        if (u !== 8'd2 || k_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_result: got u=%0d k=%b, expected u=2 k=0", u, k_out);
        end
        n_tests++;
        if (bb || um) begin
            n_fail++;
            $display("FAIL stall_hold: got busy_gap=%b u_moved=%b, expected 0 0", bb, um);
        end
    endtask

    task automatic test_handshake();
        int lat, nd; bit bb, um, bt;
        do_op(2'd0, 8'd20, 8'd30, 1'b0, 0, 0, 3, 2'd1, 8'd100, 8'd100, lat, nd, bb, um, bt);
        n_tests++;
        if (u !== 8'd50 || k_out !== 1'b0 || nd !== 1 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL start_while_run: got u=%0d k=%b pulses=%0d cycle=%0d, expected 50 0 1 %0d",
                     u, k_out, nd, lat, W + 1);
        end
        do_op(2'd0, 8'd20, 8'd30, 1'b0, 0, 0, W, 2'd2, 8'd7, 8'd9, lat, nd, bb, um, bt);
        n_tests++;
        if (u !== 8'd50 || nd !== 1 || bt) begin
            n_fail++;
            $display("FAIL start_in_done: got u=%0d pulses=%0d restarted=%b, expected 50 1 0", u, nd, bt);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, nd; bit bb, um, bt;
        mode = 2'd0; x = 8'hAA; y = 8'h55; k_in = 1'b0; en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, done, u, k_out, eq, gt} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: got busy=%b done=%b u=%0d k=%b, expected 0 0 0 0", busy, done, u, k_out);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL reset_no_done: got done=1 after abort, expected 0");
            end
        end
        do_op(2'd0, 8'd255, 8'd1, 1'b0, 0, 0, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
        n_tests++;
        if (u !== 8'd0 || k_out !== 1'b1 || lat !== W + 1) begin
            n_fail++;
            $display("FAIL after_reset_add: got u=%0d k=%b cycle=%0d, expected 0 1 %0d", u, k_out, lat, W + 1);
        end
    endtask

    task automatic test_random();
        int lat, nd; bit bb, um, bt;
        logic [1:0] m; logic [W-1:0] a, b; logic ki;
        logic [W-1:0] eu; logic ek, eeq, egt;
        int sf, sl;
        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = (i % 8 == 0) ? a : W'($urandom);
            ki = 1'($urandom);
            sf = $urandom_range(0, W - 1);
            sl = $urandom_range(0, 3);
            model(m, a, b, ki, eu, ek, eeq, egt);
            do_op(m, a, b, ki, sf, sl, -1, 2'd0, '0, '0, lat, nd, bb, um, bt);
            n_tests++;
            if (u !== eu || k_out !== ek || eq !== eeq || gt !== egt) begin
                n_fail++;
                $display("FAIL rand_result[%0d] m=%0d x=%0d y=%0d k=%b: got u=%0d k=%b eq=%b gt=%b, expected u=%0d k=%b eq=%b gt=%b",
                         i, m, a, b, ki, u, k_out, eq, gt, eu, ek, eeq, egt);
            end
            n_tests++;
            if (lat !== W + 1 + sl || nd !== 1 || bb || um) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: got cycle=%0d pulses=%0d busy_gap=%b u_moved=%b, expected cycle=%0d 1 0 0",
                         i, lat, nd, bb, um, W + 1 + sl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_stall();
        test_handshake();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
# bit_serial_alu

Parametrised bit-serial arithmetic engine built around the single-bit cascade cell (En, X, Y, K_in → U, K_out). One bit-slice processes one operand bit per clock, LSB first, with the cascade signal K held in a register between cycles. The engine supports add, subtract and unsigned compare over WIDTH-bit operands, with a start/busy/done handshake and an enable-driven stall. It is the sequential, width-generalised successor to the combinational cell and serves as the lab datapath's shared arithmetic unit.

## Interface
- WIDTH, default 8: operand/result width in bits; must be ≥ 2.
- CNT_W, default $clog2(WIDTH): bit-counter width (derived; do not override).

- clk  in  1  rising-edge clock; the single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- en  in  1  cycle enable; low during RUN stalls the engine (no bit processed, no state change).
- mode  in  2  00 add, 01 sub, 10 compare, 11 reserved (executes as add).
- x  in  WIDTH  operand X; captured on the start edge.
- y  in  WIDTH  operand Y; captured on the start edge.
- k_in  in  1  initial cascade bit: carry-in (add) or borrow-in (sub); ignored in compare.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- u  out  WIDTH  result word.
- k_out  out  1  final carry (add) or borrow (sub, compare).
- eq  out  1  compare: x == y; 0 in other modes.
- gt  out  1  compare: x > y (unsigned); 0 in other modes.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: when start=1, latch x, y and mode into shift registers, clear the bit counter, and go to RUN. The cascade register is loaded as follows:
  - add: k = k_in.
  - sub: k = ~k_in (carry form of borrow).
  - compare: k = 1.
- The y operand is inverted at latch time for sub and compare.
- RUN, en=1: the slice computes sum = x0^y0^k and carry = majority(x0, y0, k). The sum shifts into u from the MSB side, x/y shift right, k takes carry, and the counter increments. When counter == WIDTH-1, go to DONE.
- RUN, en=0: hold all registers.
- DONE: assert done for one cycle, then return to IDLE. Output flags are set as follows:
  - add: k_out = final carry.
  - sub/compare: k_out = ~final carry (borrow).
  - compare: eq = (u == 0); gt = final carry & (u != 0).
  - eq and gt are cleared for non-compare modes.
- u, k_out, eq and gt hold until the next start.
- start is ignored while busy. start and en are independent; en has no effect in IDLE or DONE.
- Arithmetic is modulo 2^WIDTH; overflow is reported only via k_out.

## Timing
- Reset values: state IDLE; busy 0; done 0; u 0; k_out 0; eq 0; gt 0; counter 0.
- Counting the start-sampling edge as edge 0 with en held high:
  - RUN occupies WIDTH cycles.
  - done is high in the cycle after edge WIDTH.
  - busy drops after edge WIDTH+1.
- Each en=0 cycle in RUN adds exactly one cycle of latency.
- A start in the same cycle that done is high is ignored. The earliest accepted restart is the first IDLE cycle.
- rst mid-operation returns all outputs to reset values immediately (asynchronously) and aborts the operation; no done is produced.

## Structure
- Package bit_serial_alu_pkg:
  - mode_t enum: MODE_ADD, MODE_SUB, MODE_CMP, MODE_RSVD.
  - state_t enum: S_IDLE, S_RUN, S_DONE.
- Sub-module bsa_slice: combinational one-bit cascade cell with ports en, x, y, k_in → u, k_out. When en=0, u=0 and k_out=k_in. Instantiate it once and drive its en from the top-level RUN & en.

## Test plan
- Add, WIDTH=8: x=200, y=100, k_in=1 → done in cycle 9; u=45; k_out=1; eq=0; gt=0.
- Sub: x=5, y=7, k_in=0 → u=254, k_out=1. Sub: x=7, y=5, k_in=1 → u=1, k_out=0.
- Compare: x=9, y=9 → eq=1, gt=0, k_out=0. x=10, y=3 → eq=0, gt=1. x=3, y=10 → eq=0, gt=0, k_out=1.
- Stall: add 1+1 with en=0 for 3 RUN cycles → done in cycle 12; u=2; busy high throughout; u unchanged during the stall.
- Handshake: pulse start while busy with different operands → ignored; the first result is unchanged and exactly one done pulse occurs.
- Reset: assert rst in the 4th RUN cycle → busy, u and done are 0 at once. A new start after rst deasserts completes correctly (255+1 → u=0, k_out=1).
